// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use/branch/mul-div stalls,
// branch flush, and a multi-cycle mul/div occupancy tracker.
module hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       MemtoRegM,
    input  logic       BranchD,
    input  logic       PCSrcD,
    input  logic       MdStartD,
    input  logic       MdOpD,
    input  logic       MdReadD,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MdBusy,
    output logic       MdDone
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    md_state_t  state;
    logic [5:0] cnt;
    logic       lwstall, brstall, mdstall, stall, md_accept;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && WriteRegM != 5'd0 && WriteRegM == RsE)      ForwardAE = 2'b10;
        else if (RegWriteW && WriteRegW != 5'd0 && WriteRegW == RsE) ForwardAE = 2'b01;

        ForwardBE = 2'b00;
        if (RegWriteM && WriteRegM != 5'd0 && WriteRegM == RtE)      ForwardBE = 2'b10;
        else if (RegWriteW && WriteRegW != 5'd0 && WriteRegW == RtE) ForwardBE = 2'b01;
    end

    assign ForwardAD = RegWriteM && WriteRegM != 5'd0 && WriteRegM == RsD;
    assign ForwardBD = RegWriteM && WriteRegM != 5'd0 && WriteRegM == RtD;

    assign lwstall = MemtoRegE && (RtE == RsD || RtE == RtD);
    assign brstall = BranchD &&
        ((RegWriteE && WriteRegE != 5'd0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
         (MemtoRegM && WriteRegM != 5'd0 && (WriteRegM == RsD || WriteRegM == RtD)));
    assign mdstall = MdBusy && (MdStartD || MdReadD);
    assign stall   = lwstall || brstall || mdstall;

    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;
    // A held decode instruction must survive, so stall masks the branch flush.
    assign FlushD = PCSrcD && !stall;

    // A start is only taken when the decode stage actually advances past it.
    assign md_accept = MdStartD && !(lwstall || brstall);

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            MdBusy <= 1'b0;
            MdDone <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (md_accept) begin
                        cnt    <= MdOpD ? DIV_LOAD : MUL_LOAD;
                        state  <= BUSY;
                        MdBusy <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        MdBusy <= 1'b0;
                    end
                    MdDone <= 1'b0;
                end
                BUSY: begin
                    if (cnt == 6'd0) begin
                        state  <= DONE;
                        MdBusy <= 1'b0;
                        MdDone <= 1'b1;
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    MdBusy <= 1'b0;
                    MdDone <= 1'b0;
                end
            endcase
        end
    end

endmodule
